pipeline_sequencer: RTL and testbench
=====================================

Name: pipeline_sequencer

Overview:
- Run-control and hazard scheduler for the 5-stage MIPS pipeline.
- Sits beside the decode-stage control unit. Consumes its Halt/MemtoReg/Jump/Branch-derived signals plus register indices.
- Drives PC/IF-ID enables, IF-ID/ID-EX flushes and the EX/MEM/WB stage enable.
- Implements run, single-step, load-use stall, branch/jump flush and halt-drain, so the debug host sees a fully retired pipeline before reading state.

Parameters:
- DRAIN_CYCLES, 3, cycles the back end (EX/MEM/WB) keeps running after HALT is accepted.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; one clock; asynchronous assert, active-low.
- start_i  in  1  debug: enter continuous RUN (level, sampled each cycle).
- step_i  in  1  debug: execute exactly one cycle (pulse).
- halt_id_i  in  1  decoded HALT opcode (6'b111111) present in ID.
- jump_id_i  in  1  decoded J in ID.
- branch_taken_ex_i  in  1  branch resolved taken in EX.
- load_ex_i  in  1  MemtoReg of instruction in EX.
- ex_rt_i  in  5  destination rt of instruction in EX.
- id_rs_i  in  5  rs of instruction in ID.
- id_rt_i  in  5  rt of instruction in ID.
- pc_en_o  out  1  PC update enable.
- ifid_en_o  out  1  IF/ID register enable.
- ifid_flush_o  out  1  IF/ID register becomes NOP.
- idex_flush_o  out  1  ID/EX register becomes NOP (bubble).
- back_en_o  out  1  EX/MEM/WB stage enable.
- halted_o  out  1  pipeline drained after HALT.
- state_o  out  3  current state encoding.
- cycle_cnt_o  out  CNT_W  cycles with back_en_o=1.
- stall_cnt_o  out  CNT_W  load-use stall cycles.

Behaviour:
- States: IDLE=0, RUN=1, STEP=2, DRAIN=3, HALTED=4. All outputs are registered-state driven. Reset: state IDLE, all outputs 0, counters 0, drain counter 0.
- IDLE: all enables 0, no flushes. start_i → RUN. Else step_i → STEP. start_i has priority over step_i.
- RUN: back_en_o=1 and pc_en_o=ifid_en_o=1 unless a hazard applies. start_i deassert → IDLE at the next edge.
- STEP: one cycle with RUN enables, then → IDLE unconditionally. step_i held high yields one step per two cycles (STEP, IDLE, STEP, …).
- Load-use stall (RUN/STEP): stall = load_ex_i && ex_rt_i!=0 && (ex_rt_i==id_rs_i || ex_rt_i==id_rt_i). During a stall: pc_en_o=0, ifid_en_o=0, idex_flush_o=1. Lasts exactly one cycle per occurrence.
- branch_taken_ex_i: ifid_flush_o=1 and idex_flush_o=1; pc_en_o stays 1. Overrides stall: pc_en_o=1, ifid_en_o=1, no stall count.
- jump_id_i (no branch, no stall): ifid_flush_o=1 only.
- HALT acceptance:
  - halt_id_i in RUN/STEP, when neither stall nor branch_taken_ex_i is active in that cycle → DRAIN. Otherwise halt_id_i is ignored that cycle; the instruction is either re-presented or squashed.
  - On acceptance: idex_flush_o=1 (HALT itself does not enter EX), pc_en_o=ifid_en_o=0.
- DRAIN: pc_en_o=ifid_en_o=0, back_en_o=1, idex_flush_o=1. Drain counter counts 0..DRAIN_CYCLES-1, then → HALTED. start_i and step_i are ignored.
- HALTED: all enables 0, halted_o=1. Sticky until rst_n.
- Reset mid-operation: immediate return to IDLE, counters cleared.
- Counters: +1 per qualifying cycle, saturate at all-ones (no wrap).

Optional Feature:
- SEQ_PERF_CNT_EN defined: cycle_cnt_o and stall_cnt_o are implemented as above.
- Undefined: no counter flops; both outputs tied to 0; ports retained.

Decomposition:
- mips_pkg holds: sequencer state localparams (IDLE..HALTED), opcode constants (HALT 6'b111111, J 6'b000010), default DRAIN_CYCLES.
- One combinational sub-module, hazard_detect: load-use compare producing stall.
- FSM, drain counter and perf counters stay in pipeline_sequencer.

Test Plan:
- Reset then start_i=1, no hazards for 10 cycles → state_o=1, pc_en_o=1 every cycle, cycle_cnt_o=10.
- RUN, load_ex_i=1, ex_rt_i=5, id_rs_i=5 for one cycle → pc_en_o=0, ifid_en_o=0, idex_flush_o=1 that cycle only; stall_cnt_o=1. Same with ex_rt_i=0 → no stall.
- Stall condition and branch_taken_ex_i=1 together → pc_en_o=1, ifid_flush_o=1, idex_flush_o=1, stall_cnt_o unchanged.
- halt_id_i=1 in RUN → DRAIN for exactly 3 cycles with back_en_o=1, pc_en_o=0, then halted_o=1. Subsequent start_i pulses leave state_o=4.
- From IDLE, step_i held 1 for 6 cycles → pc_en_o pattern 1,0,1,0,1,0; cycle_cnt_o=3.
- rst_n low mid-DRAIN (drain count=1) → state_o=0, all outputs 0 asynchronously. After release, start_i → normal RUN.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants for the MIPS pipeline run-control logic: sequencer state
// encodings, the opcodes the sequencer cares about and the default drain depth.
package mips_pkg;

  localparam logic [2:0] SEQ_IDLE   = 3'd0;
  localparam logic [2:0] SEQ_RUN    = 3'd1;
  localparam logic [2:0] SEQ_STEP   = 3'd2;
  localparam logic [2:0] SEQ_DRAIN  = 3'd3;
  localparam logic [2:0] SEQ_HALTED = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = SEQ_IDLE,
    RUN    = SEQ_RUN,
    STEP   = SEQ_STEP,
    DRAIN  = SEQ_DRAIN,
    HALTED = SEQ_HALTED
  } seq_state_e;

  localparam logic [5:0] OP_HALT = 6'b111111;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam int DRAIN_CYCLES_DEF = 3;

  function automatic logic isHaltOpcode(input logic [5:0] opcode);
    return opcode == OP_HALT;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection: the load in EX writes a register the ID
// instruction reads, so ID must wait one cycle for the loaded value.
module hazard_detect (
  input  logic       load_ex_i,
  input  logic [4:0] ex_rt_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  output logic       stall_o
);

  // $zero is never really written, so a load into r0 cannot create a hazard.
  assign stall_o = load_ex_i && (ex_rt_i != 5'd0) &&
                   ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));

endmodule

// File: rtl/pipeline_sequencer.sv
// Run-control and hazard scheduler for the 5-stage MIPS pipeline.
// Define SEQ_PERF_CNT_EN to build the cycle/stall performance counters.
module pipeline_sequencer
  import mips_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             step_i,
  input  logic             halt_id_i,
  input  logic             jump_id_i,
  input  logic             branch_taken_ex_i,
  input  logic             load_ex_i,
  input  logic [4:0]       ex_rt_i,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  output logic             pc_en_o,
  output logic             ifid_en_o,
  output logic             ifid_flush_o,
  output logic             idex_flush_o,
  output logic             back_en_o,
  output logic             halted_o,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int DrainW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DrainW-1:0] DrainLast = DrainW'(DRAIN_CYCLES - 1);

  seq_state_e        state_q, state_d;
  logic [DrainW-1:0] drainCnt_q, drainCnt_d;
  logic              stall;

  hazard_detect u_hazard_detect (
    .load_ex_i (load_ex_i),
    .ex_rt_i   (ex_rt_i),
    .id_rs_i   (id_rs_i),
    .id_rt_i   (id_rt_i),
    .stall_o   (stall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      drainCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      drainCnt_q <= drainCnt_d;
    end
  end

  // Hazard priority in RUN/STEP: taken branch, then load-use stall, then HALT
  // acceptance, then jump. A HALT seen alongside a stall or branch is ignored.
  always_comb begin
    state_d      = state_q;
    drainCnt_d   = drainCnt_q;
    pc_en_o      = 1'b0;
    ifid_en_o    = 1'b0;
    ifid_flush_o = 1'b0;
    idex_flush_o = 1'b0;
    back_en_o    = 1'b0;
    halted_o     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
        end else if (step_i) begin
          state_d = STEP;
        end
      end

      RUN, STEP: begin
        back_en_o = 1'b1;
        pc_en_o   = 1'b1;
        ifid_en_o = 1'b1;
        state_d   = (state_q == RUN && start_i) ? RUN : IDLE;
        if (branch_taken_ex_i) begin
          ifid_flush_o = 1'b1;
          idex_flush_o = 1'b1;
        end else if (stall) begin
          pc_en_o      = 1'b0;
          ifid_en_o    = 1'b0;
          idex_flush_o = 1'b1;
        end else if (halt_id_i) begin
          pc_en_o      = 1'b0;
          ifid_en_o    = 1'b0;
          idex_flush_o = 1'b1;
          state_d      = DRAIN;
          drainCnt_d   = '0;
        end else if (jump_id_i) begin
          ifid_flush_o = 1'b1;
        end
      end

      DRAIN: begin
        back_en_o    = 1'b1;
        idex_flush_o = 1'b1;
        if (drainCnt_q == DrainLast) begin
          state_d    = HALTED;
          drainCnt_d = '0;
        end else begin
          drainCnt_d = drainCnt_q + DrainW'(1);
        end
      end

      HALTED: begin
        halted_o = 1'b1;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign state_o = state_q;

`ifdef SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] cycleCnt_q, stallCnt_q;
  logic             stallHit;

  // A stall only counts when it actually held the front end (no branch override).
  assign stallHit = ((state_q == RUN) || (state_q == STEP)) &&
                    stall && !branch_taken_ex_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycleCnt_q <= '0;
      stallCnt_q <= '0;
    end else begin
      if (back_en_o && (cycleCnt_q != '1)) begin
        cycleCnt_q <= cycleCnt_q + CNT_W'(1);
      end
      if (stallHit && (stallCnt_q != '1)) begin
        stallCnt_q <= stallCnt_q + CNT_W'(1);
      end
    end
  end

  assign cycle_cnt_o = cycleCnt_q;
  assign stall_cnt_o = stallCnt_q;
`else
  assign cycle_cnt_o = '0;
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed self-checking bench for pipeline_sequencer.
// Counter expectations follow SEQ_PERF_CNT_EN (zero when it is undefined).
module tb_pipeline_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start_i, step_i, halt_id_i, jump_id_i, branch_taken_ex_i, load_ex_i;
  logic [4:0]  ex_rt_i, id_rs_i, id_rt_i;
  logic        pc_en_o, ifid_en_o, ifid_flush_o, idex_flush_o, back_en_o, halted_o;
  logic [2:0]  state_o;
  logic [31:0] cycle_cnt_o, stall_cnt_o;

  int nChecks = 0;
  int nErrors = 0;

  pipeline_sequencer #(.DRAIN_CYCLES(3), .CNT_W(32)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start_i           (start_i),
    .step_i            (step_i),
    .halt_id_i         (halt_id_i),
    .jump_id_i         (jump_id_i),
    .branch_taken_ex_i (branch_taken_ex_i),
    .load_ex_i         (load_ex_i),
    .ex_rt_i           (ex_rt_i),
    .id_rs_i           (id_rs_i),
    .id_rt_i           (id_rt_i),
    .pc_en_o           (pc_en_o),
    .ifid_en_o         (ifid_en_o),
    .ifid_flush_o      (ifid_flush_o),
    .idex_flush_o      (idex_flush_o),
    .back_en_o         (back_en_o),
    .halted_o          (halted_o),
    .state_o           (state_o),
    .cycle_cnt_o       (cycle_cnt_o),
    .stall_cnt_o       (stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] expCnt(input int n);
`ifdef SEQ_PERF_CNT_EN
    return 32'(n);
`else
    return (n > 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic start, input logic step, input logic halt,
                               input logic jump, input logic br, input logic load,
                               input logic [4:0] exRt, input logic [4:0] idRs,
                               input logic [4:0] idRt);
    start_i           = start;
    step_i            = step;
    halt_id_i         = halt;
    jump_id_i         = jump;
    branch_taken_ex_i = br;
    load_ex_i         = load;
    ex_rt_i           = exRt;
    id_rs_i           = idRs;
    id_rt_i           = idRt;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    doReset();
    checkOutput("rst_state", 32'(state_o), 32'd0);
    checkOutput("rst_pc_en", 32'(pc_en_o), 32'd0);
    checkOutput("rst_back_en", 32'(back_en_o), 32'd0);
    checkOutput("rst_halted", 32'(halted_o), 32'd0);
    checkOutput("rst_cycle_cnt", cycle_cnt_o, 32'd0);
    checkOutput("rst_stall_cnt", stall_cnt_o, 32'd0);

    // Continuous run, no hazards
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput($sformatf("run_state_%0d", i), 32'(state_o), 32'd1);
      checkOutput($sformatf("run_pc_en_%0d", i), 32'(pc_en_o), 32'd1);
    end
    tick();
    checkOutput("run_cycle_cnt", cycle_cnt_o, expCnt(10));

    // Load-use stall on rs
    applyStimulus(1, 0, 0, 0, 0, 1, 5'd5, 5'd5, 5'd1);
    checkOutput("stall_pc_en", 32'(pc_en_o), 32'd0);
    checkOutput("stall_ifid_en", 32'(ifid_en_o), 32'd0);
    checkOutput("stall_idex_flush", 32'(idex_flush_o), 32'd1);
    checkOutput("stall_ifid_flush", 32'(ifid_flush_o), 32'd0);
    tick();
    checkOutput("stall_cnt_1", stall_cnt_o, expCnt(1));
    applyStimulus(1, 0, 0, 0, 0, 0, 5'd5, 5'd5, 5'd1);
    checkOutput("post_stall_pc_en", 32'(pc_en_o), 32'd1);
    checkOutput("post_stall_idex_flush", 32'(idex_flush_o), 32'd0);

    // Load into r0 is never a hazard
    applyStimulus(1, 0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0);
    checkOutput("r0_pc_en", 32'(pc_en_o), 32'd1);
    checkOutput("r0_idex_flush", 32'(idex_flush_o), 32'd0);
    tick();
    checkOutput("r0_stall_cnt", stall_cnt_o, expCnt(1));

    // Load-use stall on rt
    applyStimulus(1, 0, 0, 0, 0, 1, 5'd7, 5'd3, 5'd7);
    checkOutput("stall_rt_pc_en", 32'(pc_en_o), 32'd0);
    tick();
    checkOutput("stall_rt_cnt", stall_cnt_o, expCnt(2));

    // Branch overrides stall
    applyStimulus(1, 0, 0, 0, 1, 1, 5'd5, 5'd5, 5'd0);
    checkOutput("br_pc_en", 32'(pc_en_o), 32'd1);
    checkOutput("br_ifid_en", 32'(ifid_en_o), 32'd1);
    checkOutput("br_ifid_flush", 32'(ifid_flush_o), 32'd1);
    checkOutput("br_idex_flush", 32'(idex_flush_o), 32'd1);
    tick();
    checkOutput("br_stall_cnt", stall_cnt_o, expCnt(2));

    // Jump flushes IF/ID only
    applyStimulus(1, 0, 0, 1, 0, 0, 0, 0, 0);
    checkOutput("j_ifid_flush", 32'(ifid_flush_o), 32'd1);
    checkOutput("j_idex_flush", 32'(idex_flush_o), 32'd0);
    checkOutput("j_pc_en", 32'(pc_en_o), 32'd1);
    tick();

    // HALT ignored while a stall is active
    applyStimulus(1, 0, 1, 0, 0, 1, 5'd9, 5'd9, 5'd0);
    tick();
    checkOutput("halt_ign_state", 32'(state_o), 32'd1);
    checkOutput("halt_ign_stall_cnt", stall_cnt_o, expCnt(3));

    // HALT accepted, three drain cycles
    applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("halt_acc_pc_en", 32'(pc_en_o), 32'd0);
    checkOutput("halt_acc_ifid_en", 32'(ifid_en_o), 32'd0);
    checkOutput("halt_acc_idex_flush", 32'(idex_flush_o), 32'd1);
    tick();
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("drain_state_%0d", i), 32'(state_o), 32'd3);
      checkOutput($sformatf("drain_back_en_%0d", i), 32'(back_en_o), 32'd1);
      checkOutput($sformatf("drain_pc_en_%0d", i), 32'(pc_en_o), 32'd0);
      checkOutput($sformatf("drain_idex_flush_%0d", i), 32'(idex_flush_o), 32'd1);
      tick();
    end
    checkOutput("halted_state", 32'(state_o), 32'd4);
    checkOutput("halted_flag", 32'(halted_o), 32'd1);
    checkOutput("halted_back_en", 32'(back_en_o), 32'd0);
    checkOutput("halted_cycle_cnt", cycle_cnt_o, expCnt(20));
    checkOutput("halted_stall_cnt", stall_cnt_o, expCnt(3));
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("halted_sticky_state", 32'(state_o), 32'd4);
    checkOutput("halted_sticky_flag", 32'(halted_o), 32'd1);

    // Single-step held high
    doReset();
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput($sformatf("step_pc_en_%0d", i), 32'(pc_en_o), (i % 2 == 0) ? 32'd1 : 32'd0);
      checkOutput($sformatf("step_state_%0d", i), 32'(state_o), (i % 2 == 0) ? 32'd2 : 32'd0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("step_cycle_cnt", cycle_cnt_o, expCnt(3));

    // Reset in the middle of drain, then start has priority over step
    doReset();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("mid_drain_state", 32'(state_o), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_state", 32'(state_o), 32'd0);
    checkOutput("async_rst_back_en", 32'(back_en_o), 32'd0);
    checkOutput("async_rst_idex_flush", 32'(idex_flush_o), 32'd0);
    checkOutput("async_rst_cycle_cnt", cycle_cnt_o, 32'd0);
    tick();
    rst_n = 1'b1;
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("restart_state", 32'(state_o), 32'd1);
    checkOutput("restart_pc_en", 32'(pc_en_o), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("stop_state", 32'(state_o), 32'd0);
    checkOutput("stop_cycle_cnt", cycle_cnt_o, expCnt(1));

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
